// File: rtl/vai_arb_pkg.sv
// Shared types and constants for the C1 Tx arbiter: FSM encoding,
// burst length decode and the default request beat type.
package vai_arb_pkg;

    // Stand-in for the platform CCI-P channel-1 request beat.
    typedef struct packed {
        logic [79:0]  hdr;
        logic [511:0] data;
        logic         valid;
    } t_if_ccip_c1_Tx;

    localparam int MAX_BURST = 4;
    localparam int BEAT_W    = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } t_arb_state;

    // Length code to beat count: 0->1, 1->2, 3->4.
    function automatic logic [BEAT_W-1:0] len_to_beats(input logic [1:0] len_code);
        return {1'b0, len_code} + BEAT_W'(1);
    endfunction

endpackage

// File: rtl/vai_rr_pick.sv
// Combinational round-robin pick: first set bit of i_mask at or after i_ptr,
// wrapping, returned both as an index and as a one-hot vector.
module vai_rr_pick #(
    parameter int N  = 8,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_mask,
    input  logic [PW-1:0] i_ptr,
    output logic          o_found,
    output logic [N-1:0]  o_onehot,
    output logic [PW-1:0] o_idx
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;

    // Rotate so that bit i_ptr lands at position 0; lowest set bit wins.
    assign w_dbl = {i_mask, i_mask} >> i_ptr;
    assign w_rot = w_dbl[N-1:0];

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                o_idx   = i_ptr + PW'(k);
            end
        end
    end

    assign o_onehot = o_found ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/vai_c1tx_arb.sv
// Round-robin packet arbiter for CCI-P channel 1 requests from sub-AFU FIFOs;
// multi-beat packets lock the grant until their last beat is popped.
module vai_c1tx_arb
    import vai_arb_pkg::*;
#(
    parameter int  NUM_SUB_AFUS = 8,
    parameter int  REQ_WIDTH    = $bits(t_if_ccip_c1_Tx),
    localparam int VW           = $clog2(NUM_SUB_AFUS)
) (
    input  logic                                   Clk,
    input  logic                                   Resetb,
    input  logic [NUM_SUB_AFUS-1:0]                req_valid,
    input  logic [NUM_SUB_AFUS-1:0][REQ_WIDTH-1:0] req_data,
    input  logic [NUM_SUB_AFUS-1:0]                req_sop,
    input  logic [NUM_SUB_AFUS-1:0][1:0]           req_len,
    output logic [NUM_SUB_AFUS-1:0]                req_rdack,
    input  logic [NUM_SUB_AFUS-1:0]                sub_afu_reset,
    input  logic                                   c1TxAlmFull,
    output logic                                   out_valid,
    output logic [REQ_WIDTH-1:0]                   out_data,
    output logic [VW-1:0]                          out_vmid,
    output logic                                   o_dbg_state,
    output logic [VW-1:0]                          o_dbg_rr_ptr,
    output logic [BEAT_W-1:0]                      o_dbg_beats_left
);

    t_arb_state                r_state, w_state_nxt;
    logic [VW-1:0]             r_rr_ptr, w_rr_ptr_nxt;
    logic [VW-1:0]             r_lock, w_lock_nxt;
    logic [BEAT_W-1:0]         r_beats_left, w_beats_left_nxt;
    logic                      r_run;
    logic                      r_out_valid;
    logic [REQ_WIDTH-1:0]      r_out_data;
    logic [VW-1:0]             r_out_vmid;

    logic [NUM_SUB_AFUS-1:0]   w_elig, w_stale, w_pick_mask, w_pick_onehot;
    logic                      w_pick_found;
    logic [VW-1:0]             w_pick_idx, w_pop_idx;
    logic [BEAT_W-1:0]         w_pick_beats;
    logic [NUM_SUB_AFUS-1:0]   w_rdack;
    logic                      w_emit;

    assign w_elig  = req_valid & req_sop  & ~sub_afu_reset;
    assign w_stale = req_valid & ~req_sop & ~sub_afu_reset;
    // Orphaned continuation beats are only flushed when no packet start is waiting.
    assign w_pick_mask  = (|w_elig) ? w_elig : w_stale;
    assign w_pick_beats = len_to_beats(req_len[w_pick_idx]);

    vai_rr_pick #(
        .N  (NUM_SUB_AFUS),
        .PW (VW)
    ) u_pick (
        .i_mask   (w_pick_mask),
        .i_ptr    (r_rr_ptr),
        .o_found  (w_pick_found),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_lock_nxt       = r_lock;
        w_beats_left_nxt = r_beats_left;
        w_rdack          = '0;
        w_emit           = 1'b0;
        w_pop_idx        = r_lock;
        case (r_state)
            ARB_IDLE: begin
                // r_run keeps the first cycle after reset release quiet.
                if (r_run && !c1TxAlmFull && w_pick_found) begin
                    w_rdack   = w_pick_onehot;
                    w_pop_idx = w_pick_idx;
                    if (|w_elig) begin
                        w_emit = 1'b1;
                        if (w_pick_beats == BEAT_W'(1)) begin
                            w_rr_ptr_nxt = w_pick_idx + VW'(1);
                        end else begin
                            w_state_nxt      = ARB_BURST;
                            w_lock_nxt       = w_pick_idx;
                            w_beats_left_nxt = w_pick_beats - BEAT_W'(1);
                        end
                    end
                end
            end
            ARB_BURST: begin
                if (sub_afu_reset[r_lock]) begin
                    w_state_nxt      = ARB_IDLE;
                    w_rr_ptr_nxt     = r_lock + VW'(1);
                    w_beats_left_nxt = '0;
                end else if (req_valid[r_lock] && !c1TxAlmFull) begin
                    w_rdack[r_lock]  = 1'b1;
                    w_emit           = 1'b1;
                    w_beats_left_nxt = r_beats_left - BEAT_W'(1);
                    if (r_beats_left == BEAT_W'(1)) begin
                        w_state_nxt  = ARB_IDLE;
                        w_rr_ptr_nxt = r_lock + VW'(1);
                    end
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            r_state      <= ARB_IDLE;
            r_rr_ptr     <= '0;
            r_lock       <= '0;
            r_beats_left <= '0;
            r_run        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_vmid   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_lock       <= w_lock_nxt;
            r_beats_left <= w_beats_left_nxt;
            r_run        <= 1'b1;
            r_out_valid  <= w_emit;
            if (w_emit) begin
                r_out_data <= req_data[w_pop_idx];
                r_out_vmid <= w_pop_idx;
            end
        end
    end

    assign req_rdack        = w_rdack;
    assign out_valid        = r_out_valid;
    assign out_data         = r_out_data;
    assign out_vmid         = r_out_vmid;
    assign o_dbg_state      = r_state;
    assign o_dbg_rr_ptr     = r_rr_ptr;
    assign o_dbg_beats_left = r_beats_left;

endmodule

// File: tb/tb_vai_c1tx_arb.sv
// Directed bench for vai_c1tx_arb: per-requester FIFOs feed the DUT, a packet-level
// model predicts every pop and output beat, and scenario checks pin grant order and timing.
module tb_vai_c1tx_arb;
    import vai_arb_pkg::*;

    localparam int N     = 8;
    localparam int W     = 16;
    localparam int VW    = 3;
    localparam int DEPTH = 128;
    localparam int LOGSZ = 1024;

    // Handshake: req_valid/req_data/req_sop/req_len describe each FIFO head; a beat
    // leaves the FIFO at the rising edge where req_rdack for that requester is high.

    logic                 Clk = 1'b0;
    logic                 Resetb = 1'b0;
    logic [N-1:0]         req_valid, req_sop, req_rdack;
    logic [N-1:0]         sub_afu_reset = '0;
    logic [N-1:0][W-1:0]  req_data;
    logic [N-1:0][1:0]    req_len;
    logic                 c1TxAlmFull = 1'b0;
    logic                 out_valid;
    logic [W-1:0]         out_data;
    logic [VW-1:0]        out_vmid;
    logic                 dbg_state;
    logic [VW-1:0]        dbg_rr;
    logic [BEAT_W-1:0]    dbg_left;

    logic [N-1:0]         gap = '0;
    logic [W-1:0]         f_data [N][DEPTH];
    logic                 f_sop  [N][DEPTH];
    logic [1:0]           f_len  [N][DEPTH];
    int                   f_wr   [N];
    int                   f_rd   [N];
    int                   seq;

    int                   errors, checks, cyc;
    int                   glog_req [LOGSZ];
    int                   glog_cyc [LOGSZ];
    int                   glog_n;
    int                   olog_vmid[LOGSZ];
    int                   olog_cyc [LOGSZ];
    int                   olog_n;
    int                   gb, ob, rel;

    int                   m_lock, m_left, m_rr;
    logic                 m_run;
    logic [VW+W-1:0]      exp_q[$];

    vai_c1tx_arb #(.NUM_SUB_AFUS(N), .REQ_WIDTH(W)) dut (
        .Clk              (Clk),
        .Resetb           (Resetb),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_sop          (req_sop),
        .req_len          (req_len),
        .req_rdack        (req_rdack),
        .sub_afu_reset    (sub_afu_reset),
        .c1TxAlmFull      (c1TxAlmFull),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_vmid         (out_vmid),
        .o_dbg_state      (dbg_state),
        .o_dbg_rr_ptr     (dbg_rr),
        .o_dbg_beats_left (dbg_left)
    );

    // Clock / reset
    always #5 Clk = ~Clk;

    // FIFO heads
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (f_rd[i] != f_wr[i]) && !gap[i];
            req_data[i]  = f_data[i][f_rd[i] % DEPTH];
            req_sop[i]   = f_sop[i][f_rd[i] % DEPTH];
            req_len[i]   = f_len[i][f_rd[i] % DEPTH];
        end
    end

    always @(posedge Clk) begin
        for (int i = 0; i < N; i++)
            if (Resetb && req_rdack[i]) f_rd[i] <= f_rd[i] + 1;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_pkt(input int r, input int len_code);
        for (int b = 0; b <= len_code; b++) begin
            f_data[r][f_wr[r] % DEPTH] = W'(r * 4096 + seq * 4 + b);
            f_sop[r][f_wr[r] % DEPTH]  = (b == 0);
            f_len[r][f_wr[r] % DEPTH]  = (b == 0) ? 2'(len_code) : 2'd0;
            f_wr[r]++;
        end
        seq++;
    endtask

    function automatic logic fifos_empty();
        for (int i = 0; i < N; i++)
            if (f_rd[i] != f_wr[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && !(fifos_empty() && dbg_state == 1'b0)) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        end
        repeat (2) tick();
    endtask

    // Grant number i (absolute log index) must be requester r, off cycles after grant gb.
    task automatic chk_g(input string nm, input int i, input int r, input int off);
        check({nm, "_req"}, 64'(glog_req[i]), 64'(r));
        check({nm, "_cyc"}, 64'(glog_cyc[i] - glog_cyc[gb]), 64'(off));
    endtask

    // Scoreboard and packet-level model, evaluated mid-cycle
    always @(negedge Clk) begin
        int              exp_pop, idx, blen;
        logic            exp_emit, found;
        logic [N-1:0]    exp_ack;
        logic [VW+W-1:0] ent;
        cyc++;
        if (!Resetb) begin
            check("rst_rdack", 64'(req_rdack), 64'd0);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_data", 64'(out_data), 64'd0);
            check("rst_out_vmid", 64'(out_vmid), 64'd0);
            check("rst_state", 64'(dbg_state), 64'd0);
            check("rst_rr", 64'(dbg_rr), 64'd0);
            check("rst_left", 64'(dbg_left), 64'd0);
            m_lock = -1;
            m_left = 0;
            m_rr   = 0;
            m_run  = 1'b0;
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0) begin
                ent = exp_q.pop_front();
                check("out_valid", 64'(out_valid), 64'd1);
                check("out_vmid", 64'(out_vmid), 64'(ent[VW+W-1:W]));
                check("out_data", 64'(out_data), 64'(ent[W-1:0]));
            end else begin
                check("out_valid_quiet", 64'(out_valid), 64'd0);
            end
            check("rr_ptr", 64'(dbg_rr), 64'(m_rr));
            check("locked", 64'(dbg_state), 64'(m_lock >= 0));
            check("beats_left", 64'(dbg_left), 64'(m_left));

            exp_pop  = -1;
            exp_emit = 1'b0;
            if (m_lock >= 0 && sub_afu_reset[m_lock]) begin
                m_rr   = (m_lock + 1) % N;
                m_lock = -1;
                m_left = 0;
            end else if (m_run && !c1TxAlmFull) begin
                if (m_lock >= 0) begin
                    if (req_valid[m_lock]) begin
                        exp_pop  = m_lock;
                        exp_emit = 1'b1;
                        m_left--;
                        if (m_left == 0) begin
                            m_rr   = (m_lock + 1) % N;
                            m_lock = -1;
                        end
                    end
                end else begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        idx = (m_rr + k) % N;
                        if (!found && req_valid[idx] && req_sop[idx] && !sub_afu_reset[idx]) begin
                            found   = 1'b1;
                            exp_pop = idx;
                        end
                    end
                    if (found) begin
                        exp_emit = 1'b1;
                        blen = int'(req_len[exp_pop]) + 1;
                        if (blen == 1) begin
                            m_rr = (exp_pop + 1) % N;
                        end else begin
                            m_lock = exp_pop;
                            m_left = blen - 1;
                        end
                    end else begin
                        for (int k = 0; k < N; k++) begin
                            idx = (m_rr + k) % N;
                            if (!found && req_valid[idx] && !req_sop[idx] && !sub_afu_reset[idx]) begin
                                found   = 1'b1;
                                exp_pop = idx;
                            end
                        end
                    end
                end
            end
            m_run = 1'b1;

            exp_ack = (exp_pop >= 0) ? (N'(1) << exp_pop) : '0;
            check("rdack", 64'(req_rdack), 64'(exp_ack));
            if (exp_emit) exp_q.push_back({VW'(exp_pop), req_data[exp_pop]});

            for (int i = 0; i < N; i++) begin
                if (req_rdack[i] && glog_n < LOGSZ) begin
                    glog_req[glog_n] = i;
                    glog_cyc[glog_n] = cyc;
                    glog_n++;
                end
            end
            if (out_valid && olog_n < LOGSZ) begin
                olog_vmid[olog_n] = int'(out_vmid);
                olog_cyc[olog_n]  = cyc;
                olog_n++;
            end
        end
    end

    // Directed scenarios
    initial begin
        int cnt;
        repeat (3) tick();
        Resetb = 1'b1;
        check("post_rst_state", 64'(dbg_state), 64'd0);
        check("post_rst_rr", 64'(dbg_rr), 64'd0);
        repeat (2) tick();

        // Single-beat packets on 0,3,5 from rr_ptr=0
        gb = glog_n; ob = olog_n;
        push_pkt(0, 0); push_pkt(3, 0); push_pkt(5, 0);
        wait_idle(50);
        check("s1_ngrants", 64'(glog_n - gb), 64'd3);
        chk_g("s1_g0", gb,     0, 0);
        chk_g("s1_g1", gb + 1, 3, 1);
        chk_g("s1_g2", gb + 2, 5, 2);
        check("s1_o0", 64'(olog_vmid[ob]), 64'd0);
        check("s1_o1", 64'(olog_vmid[ob + 1]), 64'd3);
        check("s1_o2", 64'(olog_vmid[ob + 2]), 64'd5);
        check("s1_olat", 64'(olog_cyc[ob] - glog_cyc[gb]), 64'd1);
        check("s1_rr", 64'(dbg_rr), 64'd6);

        // 4-beat packet on 2 keeps the lock while 1 waits
        push_pkt(1, 0);
        wait_idle(50);
        check("s2_rr_pre", 64'(dbg_rr), 64'd2);
        gb = glog_n;
        push_pkt(2, 3); push_pkt(1, 0);
        wait_idle(50);
        chk_g("s2_b1", gb,     2, 0);
        chk_g("s2_b2", gb + 1, 2, 1);
        chk_g("s2_b3", gb + 2, 2, 2);
        chk_g("s2_b4", gb + 3, 2, 3);
        chk_g("s2_r1", gb + 4, 1, 4);
        check("s2_rr", 64'(dbg_rr), 64'd2);

        // almFull stall of 3 cycles after beat 2, then a req_valid gap before beat 4
        gb = glog_n; ob = olog_n;
        push_pkt(2, 3);
        tick(); tick();
        c1TxAlmFull = 1'b1;
        repeat (3) tick();
        c1TxAlmFull = 1'b0;
        tick();
        gap[2] = 1'b1;
        push_pkt(6, 0);
        tick();
        gap[2] = 1'b0;
        wait_idle(50);
        chk_g("s3_b1", gb,     2, 0);
        chk_g("s3_b2", gb + 1, 2, 1);
        chk_g("s3_b3", gb + 2, 2, 5);
        chk_g("s3_b4", gb + 3, 2, 7);
        chk_g("s3_r6", gb + 4, 6, 8);
        check("s3_ogap", 64'(olog_cyc[ob + 2] - olog_cyc[ob + 1]), 64'd4);
        check("s3_o4", 64'(olog_vmid[ob + 4]), 64'd6);
        check("s3_rr", 64'(dbg_rr), 64'd7);

        // sub_afu_reset[2] after beat 1 aborts the lock; stale beats dropped later
        gb = glog_n; ob = olog_n;
        push_pkt(2, 3);
        tick();
        sub_afu_reset[2] = 1'b1;
        push_pkt(3, 0); push_pkt(0, 0);
        repeat (4) tick();
        sub_afu_reset[2] = 1'b0;
        push_pkt(5, 0);
        wait_idle(50);
        check("s4_ngrants", 64'(glog_n - gb), 64'd7);
        chk_g("s4_b1", gb,     2, 0);
        chk_g("s4_r3", gb + 1, 3, 2);
        chk_g("s4_r0", gb + 2, 0, 3);
        chk_g("s4_r5", gb + 3, 5, 5);
        chk_g("s4_d0", gb + 4, 2, 6);
        chk_g("s4_d2", gb + 6, 2, 8);
        check("s4_nout", 64'(olog_n - ob), 64'd4);
        check("s4_o3", 64'(olog_vmid[ob + 3]), 64'd5);
        check("s4_rr", 64'(dbg_rr), 64'd6);

        // Resetb pulse mid-burst on requester 4
        gb = glog_n;
        push_pkt(4, 3);
        tick(); tick();
        Resetb = 1'b0;
        push_pkt(7, 0); push_pkt(0, 0);
        repeat (3) tick();
        check("s5_pre_n", 64'(glog_n - gb), 64'd2);
        check("s5_in_rst_ov", 64'(out_valid), 64'd0);
        Resetb = 1'b1;
        check("s5_state", 64'(dbg_state), 64'd0);
        check("s5_rr", 64'(dbg_rr), 64'd0);
        rel = cyc;
        gb = glog_n; ob = olog_n;
        wait_idle(50);
        check("s5_first", 64'(glog_cyc[gb] - rel), 64'd2);
        chk_g("s5_r0", gb,     0, 0);
        chk_g("s5_r7", gb + 1, 7, 1);
        chk_g("s5_d0", gb + 2, 4, 2);
        chk_g("s5_d1", gb + 3, 4, 3);
        check("s5_nout", 64'(olog_n - ob), 64'd2);

        // All requesters busy with 1-beat packets for 64 cycles
        gb = glog_n; ob = olog_n;
        for (int r = 0; r < N; r++)
            for (int p = 0; p < 8; p++) push_pkt(r, 0);
        wait_idle(200);
        check("s6_ngrants", 64'(glog_n - gb), 64'd64);
        check("s6_span", 64'(glog_cyc[gb + 63] - glog_cyc[gb]), 64'd63);
        check("s6_first", 64'(glog_req[gb]), 64'd0);
        check("s6_ninth", 64'(glog_req[gb + 9]), 64'd1);
        for (int r = 0; r < N; r++) begin
            cnt = 0;
            for (int i = gb; i < gb + 64; i++)
                if (glog_req[i] == r) cnt++;
            check($sformatf("s6_count%0d", r), 64'(cnt), 64'd8);
        end
        check("s6_nout", 64'(olog_n - ob), 64'd64);
        check("s6_ospan", 64'(olog_cyc[ob + 63] - olog_cyc[ob]), 64'd63);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
